// File: rtl/comp_seq_nbit.sv
// Multi-cycle magnitude comparator: walks two WIDTH-bit operands MSB-first,
// CHUNK bits per clock, and stops at the first differing slice.
module comp_seq_nbit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 2,
  localparam int NCH = WIDTH / CHUNK,
  localparam int CW  = $clog2(NCH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [CW-1:0]    nchunks
);

  // Handshake: start is taken on any edge where busy=0; done pulses for one
  // cycle with eq/gt/lt/nchunks valid, and those hold until the next done.
  typedef enum logic {IDLE = 1'b0, CMP = 1'b1} state_t;

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order, so the slice walk itself is always unsigned.
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [CW-1:0]    idx;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;

  always_comb begin
    slice_a = CHUNK'(op_a >> (int'(idx) * CHUNK));
    slice_b = CHUNK'(op_b >> (int'(idx) * CHUNK));
  end

  // With only two states, busy is the state register itself.
  assign busy = (state == CMP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      idx     <= '0;
      done    <= 1'b0;
      eq      <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
      nchunks <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a ^ (signed_mode ? SIGN_MASK : '0);
            op_b  <= b ^ (signed_mode ? SIGN_MASK : '0);
            idx   <= CW'(NCH - 1);
            state <= CMP;
          end
        end
        CMP: begin
          // abort wins over a decision landing on the same edge
          if (abort) begin
            state <= IDLE;
          end else if (slice_a != slice_b) begin
            eq      <= 1'b0;
            gt      <= (slice_a > slice_b);
            lt      <= (slice_a < slice_b);
            nchunks <= CW'(NCH) - idx;
            done    <= 1'b1;
            state   <= IDLE;
          end else if (idx == '0) begin
            eq      <= 1'b1;
            gt      <= 1'b0;
            lt      <= 1'b0;
            nchunks <= CW'(NCH);
            done    <= 1'b1;
            state   <= IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comp_seq_nbit.sv
// Directed bench for comp_seq_nbit (WIDTH=16, CHUNK=2): latency, results,
// start/abort/reset corner cases, plus a short back-to-back random sweep.
module tb_comp_seq_nbit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_mode;
  logic        abort;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic        eq;
  logic        gt;
  logic        lt;
  logic [3:0]  nchunks;

  int n_assert;
  int n_fail;

  comp_seq_nbit #(.WIDTH(16), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .abort(abort), .busy(busy), .done(done),
    .eq(eq), .gt(gt), .lt(lt), .nchunks(nchunks)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $error("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Steps until done is seen, starting from cycle c0; cycle budget bounded.
  task automatic wait_done(input int c0, output int c);
    c = c0;
    while (!done && c < c0 + 40) begin
      chk("busy_while_running", 32'(busy), 32'd1);
      step();
      c++;
    end
  endtask

  // exp_r is {eq, gt, lt}; exp_k is slices examined (done expected in k+1)
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic m, input logic [2:0] exp_r, input int exp_k);
    int cyc;
    a = av; b = bv; signed_mode = m; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(1, cyc);
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_k + 1));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "_result"}, 32'({eq, gt, lt}), 32'(exp_r));
    chk({tag, "_nchunks"}, 32'(nchunks), 32'(exp_k));
  endtask

  // Reference: language-level compare and first differing slice from MSB
  function automatic void ref_cmp(input logic [15:0] av, input logic [15:0] bv, input logic m,
                                  output logic [2:0] r, output int k);
    logic found;
    if (av == bv) r = 3'b100;
    else if (m ? ($signed(av) > $signed(bv)) : (av > bv)) r = 3'b010;
    else r = 3'b001;
    k = 8;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!found && av[2*i +: 2] != bv[2*i +: 2]) begin
        k = 8 - i;
        found = 1'b1;
      end
    end
  endfunction

  initial begin
    int cyc;
    int pulses;
    logic [2:0] r;
    int k;
    logic [15:0] ra;
    logic [15:0] rb;
    logic rm;

    n_assert = 0;
    n_fail = 0;
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; abort = 1'b0;
    a = '0; b = '0;
    #2;
    chk("reset_outputs", 32'({busy, done, eq, gt, lt, nchunks}), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle_after_reset", 32'({busy, done}), 32'd0);

    // basic results and latency
    run_op("eq_1234", 16'h1234, 16'h1234, 1'b0, 3'b100, 8);
    run_op("u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 3'b010, 1);
    run_op("s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 3'b001, 1);
    run_op("u_00f0_00f1", 16'h00F0, 16'h00F1, 1'b0, 3'b001, 8);
    run_op("s_ffff_fffe", 16'hFFFF, 16'hFFFE, 1'b1, 3'b010, 8);
    run_op("s_zero_eq", 16'h0000, 16'h0000, 1'b1, 3'b100, 8);
    run_op("u_slice4", 16'h0100, 16'h0000, 1'b0, 3'b010, 4);
    run_op("s_m1_p1", 16'hFFFF, 16'h0001, 1'b1, 3'b001, 1);
    run_op("u_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 3'b010, 1);

    // start while busy is ignored; start in the done cycle is accepted
    a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    a = 16'h0000; b = 16'hFFFF; signed_mode = 1'b1; start = 1'b1;
    step();
    step();
    step();
    start = 1'b0;
    wait_done(5, cyc);
    chk("ignore_start_done_cycle", 32'(cyc), 32'd9);
    chk("ignore_start_result", 32'({eq, gt, lt}), 32'b100);
    chk("ignore_start_nchunks", 32'(nchunks), 32'd8);
    a = 16'h8000; b = 16'h7FFF; signed_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("start_in_done_busy", 32'({busy, done}), 32'b10);
    step();
    chk("start_in_done_done", 32'(done), 32'd1);
    chk("start_in_done_result", 32'({eq, gt, lt, nchunks}), 32'({3'b010, 4'd1}));

    // asynchronous reset mid-compare
    a = 16'h00F0; b = 16'h00F1; signed_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", 32'({busy, done, eq, gt, lt, nchunks}), 32'd0);
    step();
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      step();
      if (done) pulses++;
    end
    chk("midreset_no_done", 32'(pulses), 32'd0);
    chk("midreset_idle", 32'(busy), 32'd0);

    // abort in cycle 3 keeps the prior result and issues no done
    run_op("pre_abort", 16'h8000, 16'h7FFF, 1'b0, 3'b010, 1);
    a = 16'h1234; b = 16'h1234; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy_cycle4", 32'({busy, done}), 32'd0);
    chk("abort_result_kept", 32'({eq, gt, lt, nchunks}), 32'({3'b010, 4'd1}));
    pulses = 0;
    repeat (12) begin
      step();
      if (done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);

    // abort on the same edge as a decision wins
    run_op("pre_abort2", 16'h1234, 16'h1234, 1'b0, 3'b100, 8);
    a = 16'h8000; b = 16'h7FFF; signed_mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_decision_nodone", 32'({busy, done}), 32'd0);
    chk("abort_decision_kept", 32'({eq, gt, lt, nchunks}), 32'({3'b100, 4'd8}));

    // abort together with start in IDLE: start wins
    a = 16'h00F0; b = 16'h00F1; signed_mode = 1'b0; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle_busy", 32'(busy), 32'd1);
    wait_done(1, cyc);
    chk("abort_start_idle_cycle", 32'(cyc), 32'd9);
    chk("abort_start_idle_result", 32'({eq, gt, lt, nchunks}), 32'({3'b001, 4'd8}));

    // back-to-back random operations in both modes
    for (int i = 0; i < 400; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ (16'd1 << $urandom_range(0, 15));
        default: rb = 16'($urandom);
      endcase
      rm = 1'($urandom_range(0, 1));
      ref_cmp(ra, rb, rm, r, k);
      run_op("rand", ra, rb, rm, r, k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
